enemy_dive_scheduler: RTL

//  Sequences enemy dive attacks for the 24-enemy formation. Tracks which enemies are alive and

---
 rtl/galaxian_pkg.sv | 23 ++
 rtl/enemy_dive_scheduler_lfsr8.sv | 23 ++
 rtl/enemy_dive_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/galaxian_pkg.sv
// Shared definitions for the galaxian enemy logic.
//   NUM_ENEMY    : formation slot count (indices 0..NUM_ENEMY-1)
//   ENEMY_SIZE   : enemy sprite size in pixels
//   enemy_idx_t  : formation slot index
//   dive_state_t : dive scheduler states
//   sat_add10    : 10-bit add clamped at 10'h3FF
package galaxian_pkg;

  localparam int unsigned NUM_ENEMY  = 24;
  localparam int unsigned ENEMY_SIZE = 15;

  typedef logic [4:0] enemy_idx_t;

  typedef enum logic [1:0] {IDLE, SELECT, DIVE, RETURN} dive_state_t;

  // Position sums are formed in 11 bits and clamp instead of wrapping.
  function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[10] ? 10'h3FF : sum[9:0];
  endfunction

endpackage

// File: rtl/enemy_dive_scheduler_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//   frame_clk : clock
//   Reset     : asynchronous active-high, loads SEED (must be nonzero)
//   enable    : advance one step per clock when high
//   value     : current LFSR state
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  output logic [7:0] value
);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      value <= SEED;
    end else if (enable) begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end

endmodule

// File: rtl/enemy_dive_scheduler.sv
// enemy_dive_scheduler: picks a live enemy every LAUNCH_PERIOD frames, flies it
// toward the ship (one shot on the way down), wraps it to the top of the
// screen and brings it back to its formation slot.
//   frame_clk, Reset      : clock, asynchronous active-high reset
//   level, lost_game      : run enable / abort; either one holds the scheduler idle
//   hit_valid, hit_index  : enemy destroyed this cycle (index >= NUM_ENEMY ignored)
//   ship_x                : homing target for the diver
//   formation_posX/Y      : current slot position per enemy
//   alive_mask            : bit i = enemy i alive
//   dive_active           : a diver is out of formation
//   dive_index/x/y        : current diver and its position
//   fire_req              : one-cycle shot request from the diver
//   wave_clear            : registered, set when alive_mask is all zero
module enemy_dive_scheduler
  import galaxian_pkg::*;
#(
  parameter int unsigned LAUNCH_PERIOD = 64,
  parameter int unsigned DIVE_STEP_Y   = 3,
  parameter int unsigned DIVE_STEP_X   = 2,
  parameter int unsigned FIRE_Y        = 240,
  parameter int unsigned SCREEN_Y_MAX  = 464,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      level,
  input  logic                      lost_game,
  input  logic                      hit_valid,
  input  logic [4:0]                hit_index,
  input  logic [9:0]                ship_x,
  input  logic [NUM_ENEMY-1:0][9:0] formation_posX,
  input  logic [NUM_ENEMY-1:0][9:0] formation_posY,
  output logic [NUM_ENEMY-1:0]      alive_mask,
  output logic                      dive_active,
  output logic [4:0]                dive_index,
  output logic [9:0]                dive_x,
  output logic [9:0]                dive_y,
  output logic                      fire_req,
  output logic                      wave_clear
);

  localparam int unsigned   TW         = (LAUNCH_PERIOD > 1) ? $clog2(LAUNCH_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LAUNCH_PERIOD - 1);
  localparam logic [9:0]    STEP_X     = 10'(DIVE_STEP_X);
  localparam logic [9:0]    STEP_Y     = 10'(DIVE_STEP_Y);

  dive_state_t          state, state_nx;
  logic [TW-1:0]        timer, timer_nx;
  logic [4:0]           sel_cnt, sel_cnt_nx;
  enemy_idx_t           cand_q, cand_q_nx;
  logic                 fired, fired_nx;
  logic [NUM_ENEMY-1:0] alive_nx;
  logic                 active_nx, fire_nx, wave_nx;
  logic [4:0]           index_nx;
  logic [9:0]           x_nx, y_nx;

  logic [7:0]           lfsr;
  logic                 unused_lfsr_hi;

  logic                 hold, hit_ok, diver_hit, abort, timer_done, cand_alive;
  logic [NUM_ENEMY-1:0] hit_mask;
  enemy_idx_t           start_slot, cand, cand_inc;
  logic [9:0]           y_next, x_toward;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (1'b1),
    .value     (lfsr)
  );

  // Slot selection only needs the low five LFSR bits.
  assign unused_lfsr_hi = ^lfsr[7:5];

  always_comb begin
    hold       = ~level | lost_game;
    hit_ok     = hit_valid && (hit_index < 5'(NUM_ENEMY));
    hit_mask   = hit_ok ? (NUM_ENEMY'(1) << hit_index) : '0;
    diver_hit  = dive_active && hit_ok && (hit_index == dive_index);
    abort      = hold | diver_hit;
    timer_done = (timer == TIMER_LAST);
    start_slot = (lfsr[4:0] >= 5'(NUM_ENEMY)) ? lfsr[4:0] - 5'(NUM_ENEMY) : lfsr[4:0];
    // First SELECT cycle starts from the LFSR; later cycles walk the latched candidate.
    cand       = (sel_cnt == '0) ? start_slot : cand_q;
    cand_inc   = (cand == enemy_idx_t'(NUM_ENEMY - 1)) ? '0 : cand + 5'd1;
    // A same-cycle hit on the candidate makes it count as dead.
    cand_alive = alive_mask[cand] & ~hit_mask[cand];
    y_next     = sat_add10(dive_y, STEP_Y);
    if (ship_x >= dive_x) begin
      x_toward = ((ship_x - dive_x) <= STEP_X) ? ship_x : sat_add10(dive_x, STEP_X);
    end else begin
      x_toward = ((dive_x - ship_x) <= STEP_X) ? ship_x : dive_x - STEP_X;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (timer_done && !wave_clear) state_nx = SELECT;
      SELECT: begin
        if (cand_alive) state_nx = DIVE;
        else if (sel_cnt == 5'(NUM_ENEMY - 1)) state_nx = IDLE;
      end
      DIVE:   if (y_next >= 10'(SCREEN_Y_MAX)) state_nx = RETURN;
      RETURN: if (y_next >= formation_posY[dive_index]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_comb begin
    timer_nx   = '0;
    sel_cnt_nx = '0;
    cand_q_nx  = cand_q;
    alive_nx   = alive_mask;
    index_nx   = dive_index;
    x_nx       = dive_x;
    y_nx       = dive_y;
    fired_nx   = fired;
    fire_nx    = 1'b0;
    unique case (state)
      IDLE: if (!hold) begin
        if (!timer_done) timer_nx = timer + TW'(1);
        else if (wave_clear) alive_nx = '1;
      end
      SELECT: begin
        if (state_nx == DIVE) begin
          index_nx = cand;
          x_nx     = formation_posX[cand];
          y_nx     = formation_posY[cand];
          fired_nx = 1'b0;
        end else if (state_nx == SELECT) begin
          sel_cnt_nx = sel_cnt + 5'd1;
          cand_q_nx  = cand_inc;
        end
      end
      DIVE: if (!abort) begin
        if (state_nx == RETURN) begin
          y_nx = '0;
          x_nx = formation_posX[dive_index];
        end else begin
          y_nx = y_next;
          x_nx = x_toward;
        end
        if (!fired && (y_next >= 10'(FIRE_Y))) begin
          fire_nx  = 1'b1;
          fired_nx = 1'b1;
        end
      end
      RETURN: if (!abort) begin
        x_nx = formation_posX[dive_index];
        y_nx = y_next;
      end
      default: ;
    endcase
    alive_nx  = alive_nx & ~hit_mask;
    active_nx = (state_nx == DIVE) || (state_nx == RETURN);
    wave_nx   = (alive_mask == '0);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      timer       <= '0;
      sel_cnt     <= '0;
      cand_q      <= '0;
      fired       <= 1'b0;
      alive_mask  <= '1;
      dive_active <= 1'b0;
      dive_index  <= '0;
      dive_x      <= '0;
      dive_y      <= '0;
      fire_req    <= 1'b0;
      wave_clear  <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      sel_cnt     <= sel_cnt_nx;
      cand_q      <= cand_q_nx;
      fired       <= fired_nx;
      alive_mask  <= alive_nx;
      dive_active <= active_nx;
      dive_index  <= index_nx;
      dive_x      <= x_nx;
      dive_y      <= y_nx;
      fire_req    <= fire_nx;
      wave_clear  <= wave_nx;
    end
  end

endmodule
